alu_sin_deserializer: RTL and testbench

//  Serial command receiver at the ALU input. Samples the `sin` line, decodes 11-bit frames and

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_frame_rx.sv | 53 +++++
 rtl/alu_sin_deserializer.sv | 116 +++++++++++
 tb/tb_alu_sin_deserializer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU command path: opcodes, byte classes,
// assembly FSM states and the CRC4 used to protect a command.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } opcode_t;

    localparam logic [2:0] OPC_AND = OP_AND;
    localparam logic [2:0] OPC_OR  = OP_OR;
    localparam logic [2:0] OPC_ADD = OP_ADD;
    localparam logic [2:0] OPC_SUB = OP_SUB;

    typedef enum logic [1:0] {
        BT_DATA = 2'd0,
        BT_CTL  = 2'd1,
        BT_ERR  = 2'd2
    } byte_type_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_CHECK   = 2'd2,
        S_OUT     = 2'd3
    } state_t;

    function automatic logic op_supported(input logic [2:0] opc);
        logic ok;
        case (opc)
            OPC_AND, OPC_OR, OPC_ADD, OPC_SUB: ok = 1'b1;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

    // x^4+x+1, init 0, no final XOR, message consumed MSB first
    function automatic logic [3:0] crc4_68(input logic [67:0] msg);
        logic [3:0] crc;
        logic       fb;
        crc = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb  = crc[3] ^ msg[i];
            crc = {crc[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
        end
        return crc;
    endfunction

endpackage

// File: rtl/alu_frame_rx.sv
// 11-bit serial frame receiver: start, type, 8-bit payload MSB first, stop.
// Emits a one-cycle byte event in the cycle after the stop-bit sample.
module alu_frame_rx
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    output logic       byte_valid,
    output byte_type_t byte_type,
    output logic [7:0] payload,
    output logic       frame_err
);

    logic       busy;
    logic [3:0] bit_cnt;
    logic [8:0] shreg;

    // Receiver drops busy on the stop sample so a start bit can be taken next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            bit_cnt    <= 4'd0;
            byte_valid <= 1'b0;
            byte_type  <= BT_DATA;
            payload    <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (!busy) begin
                if (!sin) begin
                    busy    <= 1'b1;
                    bit_cnt <= 4'd0;
                end
            end else if (bit_cnt == 4'd9) begin
                busy       <= 1'b0;
                byte_valid <= 1'b1;
                frame_err  <= ~sin;
                payload    <= shreg[7:0];
                byte_type  <= !sin ? BT_ERR : (shreg[8] ? BT_CTL : BT_DATA);
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (busy && bit_cnt != 4'd9) begin
            shreg <= {shreg[7:0], sin};
        end
    end

endmodule

// File: rtl/alu_sin_deserializer.sv
// Assembles serial data/control bytes into {B, A, op}, validates byte count,
// CRC4 and opcode, and emits a one-cycle command or error strobe.
module alu_sin_deserializer
    import alu_pkg::*;
#(
    parameter int DATA_BYTES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic [31:0] b_data,
    output logic [31:0] a_data,
    output logic [2:0]  op,
    output logic        cmd_valid,
    output logic        err_valid,
    output logic        err_data,
    output logic        err_crc,
    output logic        err_op
);

    logic       byte_valid;
    byte_type_t byte_type;
    logic [7:0] payload;
    logic       frame_err;

    alu_frame_rx u_rx (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .byte_valid (byte_valid),
        .byte_type  (byte_type),
        .payload    (payload),
        .frame_err  (frame_err)
    );

    state_t      state, state_nxt;
    logic [63:0] ba;
    logic [3:0]  cnt;
    logic [2:0]  op_q;
    logic [3:0]  crc_q;
    logic        ferr_q;
    logic        is_data;
    logic        bad_data, bad_crc, bad_op;

    assign is_data  = byte_valid && (byte_type == BT_DATA);
    assign bad_data = ferr_q || (cnt != 4'(DATA_BYTES));
    assign bad_crc  = crc_q != crc4_68({ba, 1'b1, op_q});
    assign bad_op   = !op_supported(op_q);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // OUT behaves like IDLE for an incoming byte so back-to-back commands are not lost.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_OUT: begin
                state_nxt = S_IDLE;
                if (byte_valid) state_nxt = is_data ? S_COLLECT : S_CHECK;
            end
            S_COLLECT: if (byte_valid && !is_data) state_nxt = S_CHECK;
            S_CHECK:   state_nxt = S_OUT;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            ferr_q    <= 1'b0;
            b_data    <= 32'h0;
            a_data    <= 32'h0;
            op        <= 3'b000;
            cmd_valid <= 1'b0;
            err_valid <= 1'b0;
            err_data  <= 1'b0;
            err_crc   <= 1'b0;
            err_op    <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            err_valid <= 1'b0;
            case (state)
                S_IDLE, S_OUT: begin
                    cnt    <= is_data ? 4'd1 : 4'd0;
                    ferr_q <= byte_valid && !is_data;
                end
                S_COLLECT: begin
                    if (is_data) cnt <= (cnt == 4'd15) ? cnt : cnt + 4'd1;
                    if (byte_valid && byte_type == BT_ERR) ferr_q <= 1'b1;
                end
                S_CHECK: begin
                    b_data    <= ba[63:32];
                    a_data    <= ba[31:0];
                    op        <= op_q;
                    err_data  <= bad_data;
                    err_crc   <= !bad_data && bad_crc;
                    err_op    <= !bad_data && !bad_crc && bad_op;
                    cmd_valid <= !bad_data && !bad_crc && !bad_op;
                    err_valid <= bad_data || bad_crc || bad_op;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (is_data && state != S_CHECK) ba <= {ba[55:0], payload};
        if (byte_valid && byte_type == BT_CTL) begin
            op_q  <= payload[6:4];
            crc_q <= payload[3:0];
        end
    end

endmodule

// File: tb/tb_alu_sin_deserializer.sv
// Scoreboard bench for alu_sin_deserializer: stimulus pushes expected strobes,
// a negedge monitor pops and compares them against the DUT.
module tb_alu_sin_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sin;
    logic [31:0] b_data, a_data;
    logic [2:0]  op;
    logic        cmd_valid, err_valid, err_data, err_crc, err_op;

    alu_sin_deserializer dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .b_data    (b_data),
        .a_data    (a_data),
        .op        (op),
        .cmd_valid (cmd_valid),
        .err_valid (err_valid),
        .err_data  (err_data),
        .err_crc   (err_crc),
        .err_op    (err_op)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_cmd;
        logic        chk_data;
        logic [31:0] b;
        logic [31:0] a;
        logic [2:0]  op;
        logic        ed;
        logic        ec;
        logic        eo;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Reference CRC as polynomial long division of msg*x^4 by x^4+x+1.
    function automatic logic [3:0] ref_crc(input logic [67:0] msg);
        logic [71:0] r;
        r = {msg, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    task automatic send_frame(input logic typ, input logic [7:0] p, input logic stop);
        logic [10:0] f;
        f = {1'b0, typ, p, stop};
        for (int i = 10; i >= 0; i--) begin
            sin = f[i];
            @(posedge clk);
            #1;
        end
        sin = 1'b1;
    endtask

    task automatic send_data(input logic [7:0] d);
        send_frame(1'b0, d, 1'b1);
    endtask

    task automatic send_ctl(input logic [2:0] o, input logic [3:0] c);
        send_frame(1'b1, {1'b0, o, c}, 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_data(w[i*8 +: 8]);
    endtask

    task automatic send_cmd(input logic [31:0] b, input logic [31:0] a,
                            input logic [2:0] o, input logic [3:0] adj);
        logic [3:0] c;
        c = ref_crc({b, a, 1'b1, o}) + adj;
        send_word(b);
        send_word(a);
        send_ctl(o, c);
    endtask

    // Called right after the last frame's stop sample; strobe lands two cycles later.
    task automatic expect_strobe(input logic is_cmd, input logic chk, input logic [31:0] b,
                                 input logic [31:0] a, input logic [2:0] o,
                                 input logic ed, input logic ec, input logic eo);
        exp_t e;
        e.is_cmd = is_cmd; e.chk_data = chk; e.b = b; e.a = a; e.op = o;
        e.ed = ed; e.ec = ec; e.eo = eo; e.at = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_b"},   64'(b_data), 64'h0);
        check({tag, "_a"},   64'(a_data), 64'h0);
        check({tag, "_op"},  64'(op), 64'h0);
        check({tag, "_str"}, 64'({cmd_valid, err_valid}), 64'h0);
        check({tag, "_err"}, 64'({err_data, err_crc, err_op}), 64'h0);
    endtask

    always @(negedge clk) begin
        if (!rst && (cmd_valid || err_valid)) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 64'({cmd_valid, err_valid}), 64'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("cmd_valid", 64'(cmd_valid), 64'(e.is_cmd));
                check("err_valid", 64'(err_valid), 64'(!e.is_cmd));
                check("err_data",  64'(err_data), 64'(e.ed));
                check("err_crc",   64'(err_crc), 64'(e.ec));
                check("err_op",    64'(err_op), 64'(e.eo));
                check("latency",   64'(cyc), 64'(e.at));
                if (e.chk_data) begin
                    check("b_data", 64'(b_data), 64'(e.b));
                    check("a_data", 64'(a_data), 64'(e.a));
                    check("op",     64'(op), 64'(e.op));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        sin = 1'b1;
        idle(3);
        check_all_zero("reset");
        rst = 1'b0;
        idle(4);

        // 1: good ADD, sent back to back frame after frame
        send_cmd(32'h2, 32'h1, 3'b100, 4'd0);
        expect_strobe(1'b1, 1'b1, 32'h2, 32'h1, 3'b100, 1'b0, 1'b0, 1'b0);
        idle(8);

        // 2: CRC off by one
        send_cmd(32'h2, 32'h1, 3'b100, 4'd1);
        expect_strobe(1'b0, 1'b1, 32'h2, 32'h1, 3'b100, 1'b0, 1'b1, 1'b0);
        idle(8);

        // 3: only 7 data bytes before the control frame
        send_word(32'hFFFF_0000);
        send_data(8'h00);
        send_data(8'h00);
        send_data(8'h01);
        send_ctl(3'b100, 4'h0);
        expect_strobe(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);
        idle(8);

        // 4: unsupported opcode with a correct CRC
        send_cmd(32'h5, 32'h7, 3'b010, 4'd0);
        expect_strobe(1'b0, 1'b1, 32'h5, 32'h7, 3'b010, 1'b0, 1'b0, 1'b1);
        idle(8);

        // 5: bad stop bit in the second data frame, then a good AND
        send_data(8'h00);
        send_frame(1'b0, 8'h00, 1'b0);
        expect_strobe(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0);
        idle(8);
        send_cmd(32'h9, 32'h3, 3'b000, 4'd0);
        expect_strobe(1'b1, 1'b1, 32'h9, 32'h3, 3'b000, 1'b0, 1'b0, 1'b0);
        idle(8);

        // 6: reset after three data bytes clears everything, then a good OR
        send_data(8'h11);
        send_data(8'h22);
        send_data(8'h33);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check_all_zero("midreset");
        idle(3);
        send_cmd(32'h0000_00F0, 32'h0000_000F, 3'b001, 4'd0);
        expect_strobe(1'b1, 1'b1, 32'hF0, 32'h0F, 3'b001, 1'b0, 1'b0, 1'b0);
        idle(20);

        check("hold_b",  64'(b_data), 64'hF0);
        check("hold_op", 64'(op), 64'h1);
        check("hold_err_clear", 64'({err_data, err_crc, err_op}), 64'h0);
        check("queue_drained", 64'(sb.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
